// File: rtl/paint_pkg.sv
// Types and constants shared by the painter, its clip helper and the pixel store.
package paint_pkg;
    localparam int CANVAS_SIZE = 180;
    localparam logic [2:0] BG_COLOR = 3'b101;

    typedef logic [2:0] color_t;

    typedef enum logic {
        PAINT = 1'b0,
        CLEAR = 1'b1
    } paint_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SWEEP = 2'd2
    } painter_state_t;
endpackage

// File: rtl/brush_painter_if.sv
// Command handshake from the MCU-interface decoder into the brush painter.
interface brush_painter_if;
    import paint_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    paint_op_t  cmd_op;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [2:0] cmd_radius;
    color_t     cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_radius, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_radius, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/brush_clip.sv
// Clips a square brush footprint (or the whole canvas for CLEAR) to canvas bounds.
module brush_clip
    import paint_pkg::*;
#(
    parameter int CANVAS_SIZE = paint_pkg::CANVAS_SIZE
) (
    input  paint_op_t  op,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [2:0] r,
    output logic [7:0] x0,
    output logic [7:0] x1,
    output logic [7:0] y0,
    output logic [7:0] y1,
    output logic       empty
);
    localparam logic signed [9:0] MAXC = 10'(CANVAS_SIZE - 1);

    // Ten bits keep cx+r from wrapping for centres near 255.
    logic signed [9:0] xl, xh, yl, yh;

    always_comb begin
        xl = $signed({2'b00, cx}) - $signed({7'b0, r});
        xh = $signed({2'b00, cx}) + $signed({7'b0, r});
        yl = $signed({2'b00, cy}) - $signed({7'b0, r});
        yh = $signed({2'b00, cy}) + $signed({7'b0, r});
        if (xl < 0)    xl = '0;
        if (yl < 0)    yl = '0;
        if (xh > MAXC) xh = MAXC;
        if (yh > MAXC) yh = MAXC;
        if (op == CLEAR) begin
            xl = '0;
            yl = '0;
            xh = MAXC;
            yh = MAXC;
        end
        empty = (xl > xh) || (yl > yh);
        x0 = xl[7:0];
        x1 = xh[7:0];
        y0 = yl[7:0];
        y1 = yh[7:0];
    end
endmodule

// File: rtl/brush_painter.sv
// Command-driven stroke generator: one clipped pixel write per cycle in raster order.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   SETUP | clipped bounds computed from latched command, counters loaded
//   SWEEP | one pixel per cycle; extra final cycle drops brush and pulses done
module brush_painter
    import paint_pkg::*;
#(
    parameter int CANVAS_SIZE = paint_pkg::CANVAS_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    brush_painter_if.slave        cmd,
    output logic                  brush,
    output color_t                newColor,
    output logic [7:0]            wx,
    output logic [7:0]            wy,
    output logic                  done
);
    painter_state_t state;
    paint_op_t      op_q;
    logic [7:0]     cx_q, cy_q;
    logic [2:0]     r_q;
    color_t         color_q;
    logic [7:0]     x0_q, x1_q, y1_q;
    logic [7:0]     x, y;
    logic           fin;

    logic [7:0] cx0, cx1, cy0, cy1;
    logic       empty;

    brush_clip #(.CANVAS_SIZE(CANVAS_SIZE)) u_clip (
        .op    (op_q),
        .cx    (cx_q),
        .cy    (cy_q),
        .r     (r_q),
        .x0    (cx0),
        .x1    (cx1),
        .y0    (cy0),
        .y1    (cy1),
        .empty (empty)
    );

    assign cmd.cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= PAINT;
            cx_q     <= '0;
            cy_q     <= '0;
            r_q      <= '0;
            color_q  <= '0;
            x0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x        <= '0;
            y        <= '0;
            fin      <= 1'b0;
            brush    <= 1'b0;
            newColor <= '0;
            wx       <= '0;
            wy       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    brush <= 1'b0;
                    if (cmd.cmd_valid) begin
                        op_q    <= cmd.cmd_op;
                        cx_q    <= cmd.cmd_x;
                        cy_q    <= cmd.cmd_y;
                        r_q     <= cmd.cmd_radius;
                        color_q <= cmd.cmd_color;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    x0_q  <= cx0;
                    x1_q  <= cx1;
                    y1_q  <= cy1;
                    x     <= cx0;
                    y     <= cy0;
                    // An empty footprint goes straight to the closing cycle.
                    fin   <= empty;
                    state <= SWEEP;
                end
                SWEEP: begin
                    if (fin) begin
                        brush <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        brush    <= 1'b1;
                        wx       <= x;
                        wy       <= y;
                        newColor <= color_q;
                        if (x == x1_q) begin
                            x   <= x0_q;
                            y   <= y + 8'd1;
                            fin <= (y == y1_q);
                        end else begin
                            x <= x + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brush_painter.sv
// Directed bench for brush_painter: strokes, clipping, clear, reset abort, held commands.
module tb_brush_painter;
    import paint_pkg::*;

    logic       clk;
    logic       reset;
    logic       brush;
    color_t     newColor;
    logic [7:0] wx, wy;
    logic       done;

    int tests = 0;
    int fails = 0;

    bit         hold_en = 0;
    paint_op_t  nxt_op;
    logic [7:0] nxt_x, nxt_y;
    logic [2:0] nxt_r;
    color_t     nxt_c;

    brush_painter_if bus ();

    brush_painter #(.CANVAS_SIZE(180)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (bus.slave),
        .brush    (brush),
        .newColor (newColor),
        .wx       (wx),
        .wy       (wy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns 1 time unit after the accepting rising edge.
    task automatic send(input paint_op_t op, input int x, input int y, input int r, input int c);
        int w;
        bus.cmd_op     = op;
        bus.cmd_x      = 8'(x);
        bus.cmd_y      = 8'(y);
        bus.cmd_radius = 3'(r);
        bus.cmd_color  = 3'(c);
        bus.cmd_valid  = 1'b1;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 40000) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 32'(w < 40000), 32'd1);
        @(posedge clk);
        #1;
        if (hold_en) begin
            bus.cmd_op     = nxt_op;
            bus.cmd_x      = nxt_x;
            bus.cmd_y      = nxt_y;
            bus.cmd_radius = nxt_r;
            bus.cmd_color  = nxt_c;
            hold_en        = 0;
        end else begin
            bus.cmd_valid = 1'b0;
        end
    endtask

    // Expected bounds are hand-derived; pass ex0 > ex1 for an empty footprint.
    task automatic stroke(input string tag, input paint_op_t op, input int x, input int y,
                          input int r, input int c, input int ex0, input int ex1,
                          input int ey0, input int ey1, input bit chain);
        int n_exp, cnt, bad, rdy_hi, ex, ey;
        bit tmo;
        n_exp = (ex0 > ex1) ? 0 : (ex1 - ex0 + 1) * (ey1 - ey0 + 1);
        send(op, x, y, r, c);
        @(negedge clk);
        chk({tag, " setup_ready"}, 32'(bus.cmd_ready), 32'd0);
        chk({tag, " setup_brush"}, 32'(brush), 32'd0);
        @(negedge clk);
        chk({tag, " pre_brush"}, 32'(brush), 32'd0);
        cnt = 0; bad = 0; rdy_hi = 0; ex = ex0; ey = ey0; tmo = 1;
        for (int k = 0; k < n_exp + 4; k++) begin
            @(negedge clk);
            if (brush !== 1'b1) begin
                tmo = 0;
                break;
            end
            if (bus.cmd_ready !== 1'b0) rdy_hi++;
            if (wx !== 8'(ex) || wy !== 8'(ey) || newColor !== 3'(c)) bad++;
            cnt++;
            if (ex == ex1) begin
                ex = ex0;
                ey++;
            end else begin
                ex++;
            end
        end
        chk({tag, " timeout"}, 32'(tmo), 32'd0);
        chk({tag, " count"}, 32'(cnt), 32'(n_exp));
        chk({tag, " pixels"}, 32'(bad), 32'd0);
        chk({tag, " busy_ready"}, 32'(rdy_hi), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        if (!chain) begin
            @(negedge clk);
            chk({tag, " done_pulse"}, 32'(done), 32'd0);
            chk({tag, " ready_after"}, 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = PAINT;
        bus.cmd_x      = '0;
        bus.cmd_y      = '0;
        bus.cmd_radius = '0;
        bus.cmd_color  = '0;
        reset = 1'b0;
        #2;
        chk("rst_brush", 32'(brush), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wx", 32'(wx), 32'd0);
        chk("rst_wy", 32'(wy), 32'd0);
        chk("rst_color", 32'(newColor), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        stroke("paint_50_60", PAINT, 50, 60, 1, 3, 49, 51, 59, 61, 0);
        stroke("paint_corner0", PAINT, 0, 0, 2, 6, 0, 2, 0, 2, 0);
        stroke("paint_corner179", PAINT, 179, 179, 7, 1, 172, 179, 172, 179, 0);
        stroke("paint_offcanvas", PAINT, 200, 10, 7, 4, 1, 0, 1, 0, 0);
        stroke("clear", CLEAR, 33, 44, 5, 5, 0, 179, 0, 179, 0);

        // Second command held valid through the first sweep.
        nxt_op = PAINT; nxt_x = 8'd10; nxt_y = 8'd20; nxt_r = 3'd1; nxt_c = 3'd4;
        hold_en = 1;
        stroke("held_first", PAINT, 100, 100, 0, 2, 100, 100, 100, 100, 1);
        stroke("held_second", PAINT, 10, 20, 1, 4, 9, 11, 19, 21, 0);

        // Reset in the middle of a clear.
        send(CLEAR, 0, 0, 0, 6);
        repeat (100) @(negedge clk);
        chk("midclear_brush", 32'(brush), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_brush", 32'(brush), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wx", 32'(wx), 32'd0);
        chk("abort_wy", 32'(wy), 32'd0);
        chk("abort_color", 32'(newColor), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(bus.cmd_ready), 32'd1);
        chk("release_brush", 32'(brush), 32'd0);
        stroke("after_reset", PAINT, 90, 5, 3, 7, 87, 93, 2, 8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
